// File: rtl/axi_lite_ctrl_slave.sv
// AXI4-Lite control/parameter register slave for an HLS accelerator core.
// Independent read and write channel FSMs decode CTRL, STATUS and a bank of
// NUM_PARAMS 32-bit parameter registers presented to the core as a flat bus.
module axi_lite_ctrl_slave #(
    parameter int unsigned NUM_PARAMS = 16,
    parameter int unsigned ADDR_BITS  = 8,
    parameter int unsigned PARAM_BASE = 'h10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [31:0]                RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    input  logic [31:0]                AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [31:0]                WDATA,
    input  logic [3:0]                 WSTRB,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic                       ap_start,
    input  logic                       ap_ready,
    input  logic                       ap_done,
    input  logic                       ap_idle,
    output logic [32*NUM_PARAMS-1:0]   params
);

    localparam int unsigned WORD_BITS  = ADDR_BITS - 2;
    localparam int unsigned PARAM_WORD = PARAM_BASE / 4;

    typedef enum logic [1:0] {WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic       {RD_ADDR, RD_DATA}          rd_state_t;

    wr_state_t            wr_state, wr_next;
    rd_state_t            rd_state, rd_next;
    logic [WORD_BITS-1:0] aw_word;
    logic [WORD_BITS-1:0] ar_word;
    logic [31:0]          param_q [NUM_PARAMS];
    logic                 done_q;
    logic [15:0]          run_count;
    logic                 busy;
    logic                 aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic                 wr_mapped, rd_mapped, ctrl_wr;
    logic [31:0]          rd_value;
    logic                 unused_addr_bits;

    // Only the word address inside the decoded window matters.
    assign ar_word = ARADDR[ADDR_BITS-1:2];
    assign busy    = ap_start | ~ap_idle;
    assign unused_addr_bits = ^{ARADDR[31:ADDR_BITS], ARADDR[1:0],
                                AWADDR[31:ADDR_BITS], AWADDR[1:0]};

    // Write channel state register.
    always_ff @(posedge clk) begin
        if (reset) wr_state <= WR_ADDR;
        else       wr_state <= wr_next;
    end

    // Write channel next state and handshake outputs; ready/valid are held low in reset.
    always_comb begin
        wr_next = wr_state;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        aw_fire = 1'b0;
        w_fire  = 1'b0;
        b_fire  = 1'b0;
        if (!reset) begin
            unique case (wr_state)
                WR_ADDR: begin
                    AWREADY = 1'b1;
                    aw_fire = AWVALID;
                    if (aw_fire) wr_next = WR_DATA;
                end
                WR_DATA: begin
                    WREADY = 1'b1;
                    w_fire = WVALID;
                    if (w_fire) wr_next = WR_RESP;
                end
                WR_RESP: begin
                    BVALID = 1'b1;
                    b_fire = BREADY;
                    if (b_fire) wr_next = WR_ADDR;
                end
                default: wr_next = WR_ADDR;
            endcase
        end
    end

    // Read channel state register.
    always_ff @(posedge clk) begin
        if (reset) rd_state <= RD_ADDR;
        else       rd_state <= rd_next;
    end

    // Read channel next state and handshake outputs.
    always_comb begin
        rd_next = rd_state;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        ar_fire = 1'b0;
        r_fire  = 1'b0;
        if (!reset) begin
            unique case (rd_state)
                RD_ADDR: begin
                    ARREADY = 1'b1;
                    ar_fire = ARVALID;
                    if (ar_fire) rd_next = RD_DATA;
                end
                RD_DATA: begin
                    RVALID = 1'b1;
                    r_fire = RREADY;
                    if (r_fire) rd_next = RD_ADDR;
                end
                default: rd_next = RD_ADDR;
            endcase
        end
    end

    // Address decode for both channels and the read data mux.
    always_comb begin
        wr_mapped = (aw_word == '0) || (32'(aw_word) == 32'd1);
        rd_mapped = (ar_word == '0) || (32'(ar_word) == 32'd1);
        rd_value  = '0;
        for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
            if (32'(aw_word) == PARAM_WORD + i) wr_mapped = 1'b1;
            if (32'(ar_word) == PARAM_WORD + i) begin
                rd_mapped = 1'b1;
                rd_value  = param_q[i];
            end
        end
        if (ar_word == '0)
            rd_value = {29'b0, ap_idle, done_q, ap_start};
        else if (32'(ar_word) == 32'd1)
            rd_value = {run_count, 15'b0, busy};
        ctrl_wr = w_fire && (aw_word == '0) && WSTRB[0];
    end

    // Latched write address and write response code.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_word <= '0;
            BRESP   <= 2'b00;
        end else begin
            if (aw_fire) aw_word <= AWADDR[ADDR_BITS-1:2];
            if (w_fire)  BRESP   <= wr_mapped ? 2'b00 : 2'b10;
        end
    end

    // Read data/response captured at the AR handshake and held until R completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            RDATA <= '0;
            RRESP <= 2'b00;
        end else if (ar_fire) begin
            RDATA <= rd_mapped ? rd_value : '0;
            RRESP <= rd_mapped ? 2'b00 : 2'b10;
        end
    end

    // Parameter registers with per-byte strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PARAMS; i++) param_q[i] <= '0;
        end else if (w_fire) begin
            for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
                if (32'(aw_word) == PARAM_WORD + i) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (WSTRB[b]) param_q[i][8*b +: 8] <= WDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    // Core handshake: start set by write beats ap_ready clear; done set beats W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            ap_start  <= 1'b0;
            done_q    <= 1'b0;
            run_count <= '0;
        end else begin
            if (ctrl_wr && WDATA[0]) ap_start <= 1'b1;
            else if (ap_ready)       ap_start <= 1'b0;
            if (ap_done)                  done_q <= 1'b1;
            else if (ctrl_wr && WDATA[1]) done_q <= 1'b0;
            if (ap_done) run_count <= run_count + 16'd1;
        end
    end

    // Flatten the parameter bank onto the core-facing bus.
    always_comb begin
        params = '0;
        for (int unsigned i = 0; i < NUM_PARAMS; i++) params[32*i +: 32] = param_q[i];
    end

endmodule

// File: tb/tb_axi_lite_ctrl_slave.sv
// Scoreboard bench for axi_lite_ctrl_slave: stimulus tasks queue expected
// B/R responses, a negedge monitor pops and compares on each handshake.
module tb_axi_lite_ctrl_slave;

    localparam int unsigned NP = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       ARADDR, AWADDR, WDATA, RDATA;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]        WSTRB;
    logic [1:0]        RRESP, BRESP;
    logic              ap_start, ap_ready, ap_done, ap_idle;
    logic [32*NP-1:0]  params;

    int checks = 0;
    int errors = 0;
    logic [31:0] pm [NP];
    logic [1:0]  bq [$];
    logic [31:0] rq_data [$];
    logic [1:0]  rq_resp [$];
    logic [1:0]  mon_b;
    logic [31:0] mon_d;
    logic [1:0]  mon_r;

    axi_lite_ctrl_slave #(.NUM_PARAMS(NP), .ADDR_BITS(8), .PARAM_BASE('h10)) dut (
        .clk(clk), .reset(reset),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .params(params)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic check_params(input string name);
        for (int i = 0; i < NP; i++)
            check($sformatf("%s_p%0d", name, i), params[32*i +: 32], pm[i]);
    endtask

    // Scoreboard monitor: one compare per completed B or R handshake.
    always @(negedge clk) begin
        if (!reset && BVALID && BREADY) begin
            if (bq.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: BRESP=%0h with no write pending", BRESP);
            end else begin
                mon_b = bq.pop_front();
                check("bresp", {30'b0, BRESP}, {30'b0, mon_b});
            end
        end
        if (!reset && RVALID && RREADY) begin
            if (rq_data.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected: RDATA=%08h with no read pending", RDATA);
            end else begin
                mon_d = rq_data.pop_front();
                mon_r = rq_resp.pop_front();
                check("rdata", RDATA, mon_d);
                check("rresp", {30'b0, RRESP}, {30'b0, mon_r});
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             input int hold);
        int n;
        bq.push_back(exp_resp);
        @(posedge clk); #1;
        AWADDR = addr; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout("aw_ready");
        @(posedge clk); #1;
        AWVALID = 1'b0; WDATA = data; WSTRB = strb; WVALID = 1'b1;
        n = 0;
        while (!WREADY && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout("w_ready");
        @(posedge clk); #1;
        WVALID = 1'b0;
        for (int h = 0; h < hold; h++) begin
            check("bvalid_hold", {31'b0, BVALID}, 32'd1);
            check("bresp_hold", {30'b0, BRESP}, {30'b0, exp_resp});
            @(posedge clk); #1;
        end
        BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout("b_valid");
        @(posedge clk); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        int n;
        rq_data.push_back(exp_data);
        rq_resp.push_back(exp_resp);
        @(posedge clk); #1;
        ARADDR = addr; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout("ar_ready");
        @(posedge clk); #1;
        ARVALID = 1'b0; RREADY = 1'b1;
        n = 0;
        while (!RVALID && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout("r_valid");
        @(posedge clk); #1;
        RREADY = 1'b0;
    endtask

    // Raise ap_done or ap_ready so it is sampled on the same edge as the W handshake.
    task automatic pulse_at_w(input bit is_done);
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #2;
            if (WVALID && WREADY) begin
                if (is_done) ap_done = 1'b1; else ap_ready = 1'b1;
                @(posedge clk); #1;
                ap_done = 1'b0; ap_ready = 1'b0;
                return;
            end
        end
        timeout("pulse_at_w");
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_arready"}, {31'b0, ARREADY}, 32'd0);
        check({name, "_rvalid"},  {31'b0, RVALID},  32'd0);
        check({name, "_rdata"},   RDATA,            32'd0);
        check({name, "_rresp"},   {30'b0, RRESP},   32'd0);
        check({name, "_awready"}, {31'b0, AWREADY}, 32'd0);
        check({name, "_wready"},  {31'b0, WREADY},  32'd0);
        check({name, "_bvalid"},  {31'b0, BVALID},  32'd0);
        check({name, "_bresp"},   {30'b0, BRESP},   32'd0);
        check({name, "_ap_start"}, {31'b0, ap_start}, 32'd0);
        for (int i = 0; i < NP; i++) pm[i] = '0;
        check_params(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_awready", {31'b0, AWREADY}, 32'd1);
        check("idle_arready", {31'b0, ARREADY}, 32'd1);

        // Parameter writes, strobes, last index, first unmapped, address aliasing.
        axi_write(32'h10, 32'h12345678, 4'hF, 2'b00, 0);
        pm[0] = 32'h12345678;
        check_params("t1");
        axi_read(32'h10, 32'h12345678, 2'b00);
        axi_write(32'h14, 32'hAABBCCDD, 4'b0101, 2'b00, 0);
        pm[1] = 32'h00BB00DD;
        check_params("t2");
        axi_read(32'h14, 32'h00BB00DD, 2'b00);
        axi_write(32'h4C, 32'hCAFEF00D, 4'hF, 2'b00, 0);
        pm[15] = 32'hCAFEF00D;
        axi_read(32'h4C, 32'hCAFEF00D, 2'b00);
        axi_write(32'h50, 32'h11111111, 4'hF, 2'b10, 0);
        axi_read(32'h50, 32'h0, 2'b10);
        axi_write(32'hFFFFFF10, 32'h99000000, 4'b1000, 2'b00, 0);
        pm[0] = 32'h99345678;
        check_params("alias");
        axi_read(32'h00000312, 32'h99345678, 2'b00);

        // Start/ready/done sequence.
        axi_write(32'h0, 32'h1, 4'hF, 2'b00, 0);
        check("start_set", {31'b0, ap_start}, 32'd1);
        axi_read(32'h0, 32'h5, 2'b00);
        repeat (5) @(posedge clk);
        #1 ap_ready = 1'b1;
        check("start_before_ready_edge", {31'b0, ap_start}, 32'd1);
        @(posedge clk); #1 ap_ready = 1'b0;
        check("start_cleared", {31'b0, ap_start}, 32'd0);
        repeat (19) @(posedge clk);
        #1 ap_done = 1'b1;
        @(posedge clk); #1 ap_done = 1'b0;
        axi_read(32'h0, 32'h6, 2'b00);
        axi_read(32'h4, 32'h00010000, 2'b00);
        ap_idle = 1'b0;
        axi_read(32'h4, 32'h00010001, 2'b00);
        axi_read(32'h0, 32'h2, 2'b00);
        ap_idle = 1'b1;
        axi_write(32'h0, 32'h3, 4'hE, 2'b00, 0);
        axi_read(32'h0, 32'h6, 2'b00);
        axi_write(32'h4, 32'hFFFFFFFF, 4'hF, 2'b00, 0);
        axi_read(32'h4, 32'h00010000, 2'b00);

        // W1C coinciding with ap_done: set wins; then a clean W1C.
        fork
            axi_write(32'h0, 32'h2, 4'hF, 2'b00, 0);
            pulse_at_w(1'b1);
        join
        axi_read(32'h0, 32'h6, 2'b00);
        axi_read(32'h4, 32'h00020000, 2'b00);
        axi_write(32'h0, 32'h2, 4'hF, 2'b00, 0);
        axi_read(32'h0, 32'h4, 2'b00);

        // Unmapped read/write leave params intact.
        axi_read(32'hF0, 32'h0, 2'b10);
        axi_write(32'hF0, 32'hDEADBEEF, 4'hF, 2'b10, 0);
        check_params("t5");

        // Start set coinciding with ap_ready: set wins.
        fork
            axi_write(32'h0, 32'h1, 4'hF, 2'b00, 0);
            pulse_at_w(1'b0);
        join
        check("start_set_wins", {31'b0, ap_start}, 32'd1);

        // Held B response with an independent concurrent read.
        fork
            axi_write(32'h18, 32'h0BADF00D, 4'hF, 2'b00, 10);
            begin
                repeat (2) @(posedge clk);
                axi_read(32'h10, 32'h99345678, 2'b00);
                check("b_still_pending", {31'b0, BVALID}, 32'd1);
            end
        join
        pm[2] = 32'h0BADF00D;
        check_params("t6");

        // Reset while in WR_DATA abandons the write.
        @(posedge clk); #1;
        AWADDR = 32'h1C; AWVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0;
        check("in_wr_data", {31'b0, WREADY}, 32'd1);
        reset = 1'b1; WDATA = 32'h55555555; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("no_b_after_reset", {31'b0, BVALID}, 32'd0);
            @(posedge clk); #1;
        end
        BREADY = 1'b0;
        check_params("post_reset");
        axi_write(32'h1C, 32'h76543210, 4'hF, 2'b00, 0);
        pm[3] = 32'h76543210;
        check_params("post_reset_wr");
        axi_read(32'h1C, 32'h76543210, 2'b00);

        repeat (5) @(posedge clk);
        check("bq_drained", bq.size(), 32'd0);
        check("rq_drained", rq_data.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
